// File: rtl/multi_player_ctl.sv
// Multi-player horizontal movement controller.
// One selected player walks left/right per frame tick. It is clamped by the
// screen edges, by a closed door region and by a minimum spacing to the
// other players. All outputs are driven from registers.
module multi_player_ctl #(
  parameter int N_PLAYERS = 2,
  parameter int X_MAX     = 760,
  parameter int DOOR_LO   = 350,
  parameter int DOOR_HI   = 450,
  parameter int STEP      = 1,
  parameter int MIN_SEP   = 40,
  parameter int Y_GROUND  = 500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      v_tick,
  input  logic                      m_left,
  input  logic                      m_right,
  input  logic [1:0]                sel,
  input  logic                      door_open,
  output logic [12*N_PLAYERS-1:0]   xpos,
  output logic [12*N_PLAYERS-1:0]   ypos,
  output logic [2*N_PLAYERS-1:0]    state,
  output logic [N_PLAYERS-1:0]      blocked
);

  typedef enum logic [1:0] {IDLE = 2'd0, RIGHT = 2'd1, LEFT = 2'd2} pstate_t;

  // Target arithmetic is done one bit wider than positions so x + STEP
  // and x + MIN_SEP cannot wrap.
  localparam logic [12:0] XMAX_W = 13'(X_MAX);
  localparam logic [12:0] DLO_W  = 13'(DOOR_LO);
  localparam logic [12:0] DHI_W  = 13'(DOOR_HI);
  localparam logic [12:0] STEP_W = 13'(STEP);
  localparam logic [12:0] SEP_W  = 13'(MIN_SEP);

  logic             v_tick_q;
  logic             tick;
  logic             sel_ok;
  logic [11:0]      x_q [N_PLAYERS];
  pstate_t          st_q [N_PLAYERS];
  logic [N_PLAYERS-1:0] blk_q;
  logic [11:0]      y_q;

  logic [12:0]      x_act;
  logic [12:0]      r_tgt_d;
  logic [12:0]      l_tgt_d;
  logic [12:0]      cand;

  assign tick   = v_tick & ~v_tick_q;
  assign sel_ok = ({1'b0, sel} < 3'(N_PLAYERS));

  // Right and left targets for the selected player, clamped by edge, door and neighbours.
  always_comb begin
    x_act   = '0;
    cand    = '0;
    r_tgt_d = '0;
    l_tgt_d = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (int'(sel) == i) x_act = {1'b0, x_q[i]};
    end

    r_tgt_d = x_act + STEP_W;
    if (r_tgt_d > XMAX_W) r_tgt_d = XMAX_W;
    if (!door_open && (x_act <= DLO_W) && (r_tgt_d > DLO_W)) r_tgt_d = DLO_W;
    for (int j = 0; j < N_PLAYERS; j++) begin
      if ((int'(sel) != j) && ({1'b0, x_q[j]} >= x_act)) begin
        cand = ({1'b0, x_q[j]} >= x_act + SEP_W) ? ({1'b0, x_q[j]} - SEP_W) : x_act;
        if (cand < r_tgt_d) r_tgt_d = cand;
      end
    end

    l_tgt_d = (x_act < STEP_W) ? 13'd0 : (x_act - STEP_W);
    if (!door_open && (x_act >= DHI_W) && (l_tgt_d < DHI_W)) l_tgt_d = DHI_W;
    for (int j = 0; j < N_PLAYERS; j++) begin
      if ((int'(sel) != j) && ({1'b0, x_q[j]} <= x_act)) begin
        cand = {1'b0, x_q[j]} + SEP_W;
        if (cand > x_act) cand = x_act;
        if (cand > l_tgt_d) l_tgt_d = cand;
      end
    end
  end

  // Per-player FSM, position and blocked flag; updated once per tick edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_tick_q <= 1'b0;
      y_q      <= 12'(Y_GROUND);
      blk_q    <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        x_q[i]  <= 12'(i * MIN_SEP);
        st_q[i] <= IDLE;
      end
    end else begin
      v_tick_q <= v_tick;
      if (tick) begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (sel_ok && (int'(sel) == i)) begin
            case (st_q[i])
              IDLE: begin
                blk_q[i] <= 1'b0;
                if (m_right)     st_q[i] <= RIGHT;
                else if (m_left) st_q[i] <= LEFT;
                else             st_q[i] <= IDLE;
              end
              RIGHT: begin
                if (!m_right) begin
                  st_q[i]  <= IDLE;
                  blk_q[i] <= 1'b0;
                end else begin
                  x_q[i]   <= r_tgt_d[11:0];
                  blk_q[i] <= (r_tgt_d == x_act);
                end
              end
              LEFT: begin
                if (!m_left) begin
                  st_q[i]  <= IDLE;
                  blk_q[i] <= 1'b0;
                end else begin
                  x_q[i]   <= l_tgt_d[11:0];
                  blk_q[i] <= (l_tgt_d == x_act);
                end
              end
              default: begin
                st_q[i]  <= IDLE;
                blk_q[i] <= 1'b0;
              end
            endcase
          end else begin
            st_q[i]  <= IDLE;
            blk_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Pack per-player registers onto the flat output buses.
  always_comb begin
    xpos    = '0;
    ypos    = '0;
    state   = '0;
    blocked = blk_q;
    for (int i = 0; i < N_PLAYERS; i++) begin
      xpos[12*i +: 12] = x_q[i];
      ypos[12*i +: 12] = y_q;
      state[2*i +: 2]  = st_q[i];
    end
  end

endmodule

// File: tb/tb_multi_player_ctl.sv
// Self-checking bench for multi_player_ctl with an integer reference model.
module tb_multi_player_ctl;

  localparam int NP  = 2;
  localparam int XM  = 760;
  localparam int DLO = 350;
  localparam int DHI = 450;
  localparam int ST  = 1;
  localparam int MS  = 40;
  localparam int YG  = 500;

  logic clk = 1'b0;
  logic rst, v_tick, m_left, m_right, door_open;
  logic [1:0] sel;
  logic [12*NP-1:0] xpos, ypos;
  logic [2*NP-1:0]  state;
  logic [NP-1:0]    blocked;

  int mx [NP];
  int ms [NP];   // 0 idle, 1 right, 2 left
  int mb [NP];
  int n_vec = 0;
  int n_err = 0;

  multi_player_ctl #(
    .N_PLAYERS(NP), .X_MAX(XM), .DOOR_LO(DLO), .DOOR_HI(DHI),
    .STEP(ST), .MIN_SEP(MS), .Y_GROUND(YG)
  ) dut (
    .clk(clk), .rst(rst), .v_tick(v_tick), .m_left(m_left), .m_right(m_right),
    .sel(sel), .door_open(door_open), .xpos(xpos), .ypos(ypos),
    .state(state), .blocked(blocked)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      mx[i] = i * MS;
      ms[i] = 0;
      mb[i] = 0;
    end
  endfunction

  // One frame update from the rules: walk, door wall, spacing to neighbours.
  function automatic void model_tick();
    int p, x, t;
    p = int'(sel);
    for (int i = 0; i < NP; i++) begin
      if (i != p) begin
        ms[i] = 0;
        mb[i] = 0;
      end
    end
    if (p < NP) begin
      x = mx[p];
      if (ms[p] == 0) begin
        ms[p] = m_right ? 1 : (m_left ? 2 : 0);
        mb[p] = 0;
      end else if (ms[p] == 1 && !m_right) begin
        ms[p] = 0;
        mb[p] = 0;
      end else if (ms[p] == 2 && !m_left) begin
        ms[p] = 0;
        mb[p] = 0;
      end else if (ms[p] == 1) begin
        t = (x + ST > XM) ? XM : x + ST;
        if (!door_open && x <= DLO && t > DLO) t = DLO;
        for (int j = 0; j < NP; j++)
          if (j != p && mx[j] >= x) begin
            int lim;
            lim = (mx[j] - MS < x) ? x : mx[j] - MS;
            if (lim < t) t = lim;
          end
        mb[p] = (t == x) ? 1 : 0;
        mx[p] = t;
      end else begin
        t = (x < ST) ? 0 : x - ST;
        if (!door_open && x >= DHI && t < DHI) t = DHI;
        for (int j = 0; j < NP; j++)
          if (j != p && mx[j] <= x) begin
            int lim;
            lim = (mx[j] + MS > x) ? x : mx[j] + MS;
            if (lim > t) t = lim;
          end
        mb[p] = (t == x) ? 1 : 0;
        mx[p] = t;
      end
    end
  endfunction

  function automatic logic [12*NP-1:0] exp_x();
    logic [12*NP-1:0] e;
    for (int i = 0; i < NP; i++) e[12*i +: 12] = 12'(mx[i]);
    return e;
  endfunction

  function automatic logic [12*NP-1:0] exp_y();
    logic [12*NP-1:0] e;
    for (int i = 0; i < NP; i++) e[12*i +: 12] = 12'(YG);
    return e;
  endfunction

  function automatic logic [2*NP-1:0] exp_s();
    logic [2*NP-1:0] e;
    for (int i = 0; i < NP; i++) e[2*i +: 2] = 2'(ms[i]);
    return e;
  endfunction

  function automatic logic [NP-1:0] exp_b();
    logic [NP-1:0] e;
    for (int i = 0; i < NP; i++) e[i] = (mb[i] != 0);
    return e;
  endfunction

  // Raise v_tick for 'hold' clock edges, drop it, then advance the model once.
  task automatic do_tick(input int hold);
    @(negedge clk);
    v_tick = 1'b1;
    repeat (hold) @(negedge clk);
    v_tick = 1'b0;
    @(negedge clk);
    model_tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (xpos !== exp_x()) begin n_err++; $display("FAIL reset_x got=%h want=%h", xpos, exp_x()); end
    n_vec++;
    if (ypos !== exp_y()) begin n_err++; $display("FAIL reset_y got=%h want=%h", ypos, exp_y()); end
    n_vec++;
    if (state !== 4'b0000) begin n_err++; $display("FAIL reset_state got=%b want=0000", state); end
    n_vec++;
    if (blocked !== 2'b00) begin n_err++; $display("FAIL reset_blocked got=%b want=00", blocked); end
  endtask

  task automatic test_walk();
    do_reset();
    sel = 2'd1; m_right = 1'b1; m_left = 1'b0; door_open = 1'b1;
    do_tick(1);
    n_vec++;
    if (state[3:2] !== 2'd1 || xpos[23:12] !== 12'd40) begin
      n_err++; $display("FAIL walk_tick1 got st=%0d x1=%0d want st=1 x1=40", state[3:2], xpos[23:12]);
    end
    repeat (10) do_tick(1);
    n_vec++;
    if (xpos[23:12] !== 12'd50 || xpos[11:0] !== 12'd0 || state[1:0] !== 2'd0) begin
      n_err++; $display("FAIL walk_tick11 got x1=%0d x0=%0d st0=%0d want 50 0 0", xpos[23:12], xpos[11:0], state[1:0]);
    end
    n_vec++;
    if (xpos !== exp_x() || state !== exp_s() || blocked !== exp_b()) begin
      n_err++; $display("FAIL walk_model got x=%h s=%b b=%b want x=%h s=%b b=%b", xpos, state, blocked, exp_x(), exp_s(), exp_b());
    end
  endtask

  task automatic test_door();
    do_reset();
    sel = 2'd1; m_right = 1'b1; m_left = 1'b0; door_open = 1'b0;
    repeat (315) do_tick(1);
    n_vec++;
    if (xpos[23:12] !== 12'd350 || blocked[1] !== 1'b1 || state[3:2] !== 2'd1) begin
      n_err++; $display("FAIL door_closed got x1=%0d b=%b st=%0d want 350 1 1", xpos[23:12], blocked[1], state[3:2]);
    end
    door_open = 1'b1;
    do_tick(1);
    n_vec++;
    if (xpos[23:12] !== 12'd351 || blocked[1] !== 1'b0) begin
      n_err++; $display("FAIL door_open got x1=%0d b=%b want 351 0", xpos[23:12], blocked[1]);
    end
    repeat (101) do_tick(1);
    door_open = 1'b0; m_right = 1'b0; m_left = 1'b1;
    repeat (6) do_tick(1);
    n_vec++;
    if (xpos[23:12] !== 12'd450 || blocked[1] !== 1'b1 || state[3:2] !== 2'd2) begin
      n_err++; $display("FAIL door_left got x1=%0d b=%b st=%0d want 450 1 2", xpos[23:12], blocked[1], state[3:2]);
    end
    n_vec++;
    if (xpos !== exp_x() || state !== exp_s() || blocked !== exp_b()) begin
      n_err++; $display("FAIL door_model got x=%h s=%b b=%b want x=%h s=%b b=%b", xpos, state, blocked, exp_x(), exp_s(), exp_b());
    end
  endtask

  task automatic test_edge_blocked();
    do_reset();
    sel = 2'd0; m_right = 1'b1; m_left = 1'b0; door_open = 1'b1;
    repeat (3) do_tick(1);
    n_vec++;
    if (xpos[11:0] !== 12'd0 || xpos[23:12] !== 12'd40 || blocked[0] !== 1'b1) begin
      n_err++; $display("FAIL sep_right got x0=%0d x1=%0d b0=%b want 0 40 1", xpos[11:0], xpos[23:12], blocked[0]);
    end
    do_reset();
    m_right = 1'b0; m_left = 1'b1;
    repeat (3) do_tick(1);
    n_vec++;
    if (xpos[11:0] !== 12'd0 || blocked[0] !== 1'b1 || state[1:0] !== 2'd2) begin
      n_err++; $display("FAIL edge_left got x0=%0d b0=%b st0=%0d want 0 1 2", xpos[11:0], blocked[0], state[1:0]);
    end
  endtask

  task automatic test_level_tick();
    do_reset();
    sel = 2'd1; m_right = 1'b1; m_left = 1'b0; door_open = 1'b1;
    repeat (61) do_tick(1);
    n_vec++;
    if (xpos[23:12] !== 12'd100) begin n_err++; $display("FAIL level_pre got x1=%0d want 100", xpos[23:12]); end
    do_tick(5);
    n_vec++;
    if (xpos[23:12] !== 12'd101) begin n_err++; $display("FAIL level_hold got x1=%0d want 101", xpos[23:12]); end
    m_right = 1'b0;
    do_tick(1);
    m_right = 1'b1; m_left = 1'b1;
    do_tick(1);
    n_vec++;
    if (state[3:2] !== 2'd1) begin n_err++; $display("FAIL both_req got st1=%0d want 1", state[3:2]); end
    do_tick(1);
    n_vec++;
    if (xpos[23:12] !== 12'd102 || xpos !== exp_x()) begin
      n_err++; $display("FAIL both_move got x=%h want x1=102 model=%h", xpos, exp_x());
    end
  endtask

  task automatic test_sel_invalid_and_reset();
    do_reset();
    sel = 2'd2; m_right = 1'b1; m_left = 1'b0; door_open = 1'b1;
    repeat (4) do_tick(1);
    n_vec++;
    if (xpos[11:0] !== 12'd0 || xpos[23:12] !== 12'd40 || state !== 4'b0000) begin
      n_err++; $display("FAIL sel_invalid got x=%h st=%b want x0=0 x1=40 st=0000", xpos, state);
    end
    sel = 2'd1;
    repeat (5) do_tick(1);
    @(negedge clk);
    v_tick = 1'b1; rst = 1'b1;
    @(negedge clk);
    v_tick = 1'b0; rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_vec++;
    if (xpos[11:0] !== 12'd0 || xpos[23:12] !== 12'd40 || state !== 4'b0000 || blocked !== 2'b00) begin
      n_err++; $display("FAIL reset_mid got x=%h st=%b b=%b want x0=0 x1=40 st=0 b=0", xpos, state, blocked);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      sel       = 2'($urandom_range(0, 3));
      m_right   = ($urandom_range(0, 3) != 0);
      m_left    = ($urandom_range(0, 2) != 0);
      door_open = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end else begin
        do_tick(int'($urandom_range(1, 3)));
      end
      n_vec++;
      if (xpos !== exp_x() || ypos !== exp_y() || state !== exp_s() || blocked !== exp_b()) begin
        n_err++;
        $display("FAIL rand_%0d got x=%h y=%h s=%b b=%b want x=%h y=%h s=%b b=%b",
                 k, xpos, ypos, state, blocked, exp_x(), exp_y(), exp_s(), exp_b());
      end
    end
  endtask

  initial begin
    rst = 1'b1; v_tick = 1'b0; m_left = 1'b0; m_right = 1'b0;
    sel = 2'd0; door_open = 1'b1;
    model_reset();
    test_reset();
    test_walk();
    test_door();
    test_edge_blocked();
    test_level_tick();
    test_sel_invalid_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
